// File: rtl/return_stream_if.sv
// PS-facing register bundle and BRAM read port of the return_stream block,
// seen as master (PS/BRAM side) or slave (return_stream side).
interface return_stream_if #(
    parameter int ADDR_WIDTH = 12
);
    logic [31:0]           slv_reg0;
    logic [31:0]           slv_reg1;
    logic [31:0]           slv_reg2;
    logic [31:0]           slv_reg3;
    logic [ADDR_WIDTH-1:0] addra;
    logic                  douta;

    modport master (
        output slv_reg0, slv_reg1, douta,
        input  slv_reg2, slv_reg3, addra
    );

    modport slave (
        input  slv_reg0, slv_reg1, douta,
        output slv_reg2, slv_reg3, addra
    );
endinterface

// File: rtl/return_stream.sv
// Reads a 1-bit BRAM bitmap over [begin..end], packs DATA_W bits per word and hands
// each word to the PS via om_work/im_work. Define RETURN_MSB_FIRST_EN for MSB-first packing.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | after reset / soft clear, waiting for a start edge
// READ    | address on addra, waiting READ_LAT cycles for the BRAM
// WAIT    | BRAM data valid, shift it into the word
// PACK    | decide: present the word or fetch the next bit
// PRESENT | om_work=1, word on slv_reg2, waiting for im_work=1
// ACKLOW  | om_work=0, waiting for im_work=0
// DONE    | window finished (or range error), outputs held
module return_stream #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_W     = 8,
    parameter int READ_LAT   = 1
) (
    input  logic           clk,
    input  logic           rst,
    return_stream_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_WAIT, S_PACK, S_PRESENT, S_ACKLOW, S_DONE
    } state_t;

    localparam logic [1:0] LAT_LOAD = 2'(READ_LAT - 1);

    state_t                state, state_n;
    logic [ADDR_WIDTH-1:0] addr, addr_n;
    logic [ADDR_WIDTH-1:0] win_begin, win_begin_n;
    logic [ADDR_WIDTH-1:0] win_end, win_end_n;
    logic [DATA_W-1:0]     data, data_n, data_ins;
    logic [5:0]            count, count_n;
    logic [1:0]            lat, lat_n;
    logic                  om_work, om_work_n;
    logic                  om_start, om_start_n;
    logic                  done, done_n;
    logic                  error, error_n;
    logic                  start_q;

    logic                  im_work, im_start, soft_clr, start_edge;
    logic [ADDR_WIDTH-1:0] cfg_begin, cfg_end;
    logic                  unused_bits;

    assign im_work     = bus.slv_reg0[0];
    assign im_start    = bus.slv_reg0[1];
    assign soft_clr    = bus.slv_reg0[4];
    assign cfg_begin   = bus.slv_reg1[ADDR_WIDTH-1:0];
    assign cfg_end     = bus.slv_reg1[16+ADDR_WIDTH-1:16];
    assign start_edge  = im_start & ~start_q;
    assign unused_bits = ^{bus.slv_reg0[31:5], bus.slv_reg0[3:2], bus.slv_reg1};

`ifdef RETURN_MSB_FIRST_EN
    assign data_ins = (data << 1) | DATA_W'(bus.douta);
`else
    assign data_ins = data | (DATA_W'(bus.douta) << count);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_q <= 1'b0;
        end else begin
            start_q <= im_start;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            addr      <= '0;
            win_begin <= '0;
            win_end   <= '0;
            data      <= '0;
            count     <= '0;
            lat       <= '0;
            om_work   <= 1'b0;
            om_start  <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            state     <= state_n;
            addr      <= addr_n;
            win_begin <= win_begin_n;
            win_end   <= win_end_n;
            data      <= data_n;
            count     <= count_n;
            lat       <= lat_n;
            om_work   <= om_work_n;
            om_start  <= om_start_n;
            done      <= done_n;
            error     <= error_n;
        end
    end

    always_comb begin
        state_n     = state;
        addr_n      = addr;
        win_begin_n = win_begin;
        win_end_n   = win_end;
        data_n      = data;
        count_n     = count;
        lat_n       = lat;
        om_work_n   = om_work;
        om_start_n  = om_start;
        done_n      = done;
        error_n     = error;

        case (state)
            S_IDLE, S_DONE: begin
                if (start_edge) begin
                    win_begin_n = cfg_begin;
                    win_end_n   = cfg_end;
                    done_n      = 1'b0;
                    error_n     = 1'b0;
                    data_n      = '0;
                    count_n     = '0;
                    if (cfg_begin > cfg_end) begin
                        error_n = 1'b1;
                        done_n  = 1'b1;
                        state_n = S_DONE;
                    end else begin
                        om_start_n = 1'b1;
                        addr_n     = cfg_begin;
                        lat_n      = LAT_LOAD;
                        state_n    = S_READ;
                    end
                end
            end
            S_READ: begin
                if (lat == 2'd0) begin
                    state_n = S_WAIT;
                end else begin
                    lat_n = lat - 2'd1;
                end
            end
            S_WAIT: begin
                data_n  = data_ins;
                count_n = count + 6'd1;
                state_n = S_PACK;
            end
            S_PACK: begin
                if (addr == win_end || count == 6'(DATA_W)) begin
                    om_work_n = 1'b1;
                    state_n   = S_PRESENT;
                end else begin
                    addr_n  = addr + 1'b1;
                    lat_n   = LAT_LOAD;
                    state_n = S_READ;
                end
            end
            S_PRESENT: begin
                // om_work is registered, so an early ack still leaves one valid cycle
                if (im_work) begin
                    om_work_n = 1'b0;
                    state_n   = S_ACKLOW;
                end
            end
            S_ACKLOW: begin
                if (!im_work) begin
                    if (addr == win_end) begin
                        om_start_n = 1'b0;
                        done_n     = 1'b1;
                        state_n    = S_DONE;
                    end else begin
                        data_n  = '0;
                        count_n = '0;
                        addr_n  = addr + 1'b1;
                        lat_n   = LAT_LOAD;
                        state_n = S_READ;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase

        if (soft_clr) begin
            state_n     = S_IDLE;
            addr_n      = '0;
            win_begin_n = '0;
            win_end_n   = '0;
            data_n      = '0;
            count_n     = '0;
            lat_n       = '0;
            om_work_n   = 1'b0;
            om_start_n  = 1'b0;
            done_n      = 1'b0;
            error_n     = 1'b0;
        end
    end

    assign bus.addra    = addr;
    assign bus.slv_reg2 = 32'(data);
    assign bus.slv_reg3 = {18'b0, count, 4'b0, error, done, om_start, om_work};

endmodule

// File: tb/tb_return_stream.sv
// Scoreboard bench for return_stream: a window model predicts the packed words,
// a monitor compares every presented word; a responder plays the PS handshake.
module tb_return_stream;
    localparam int ADDR_WIDTH = 12;
    localparam int DATA_W     = 8;
    localparam int READ_LAT   = 2;
    localparam int MEM_DEPTH  = 1 << ADDR_WIDTH;

    typedef struct {
        logic [31:0] data;
        logic [5:0]  cnt;
    } word_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic im_work = 1'b0;
    logic im_start = 1'b0;
    logic soft_clr = 1'b0;
    int   ack_mode = 0;   // 0: normal random-delay ack, 1: hold high, 2: never ack
    int   tests = 0;
    int   fails = 0;
    word_t exp_q[$];
    bit   mem [0:MEM_DEPTH-1];
    logic rd_pipe [0:READ_LAT-1];

    return_stream_if #(.ADDR_WIDTH(ADDR_WIDTH)) bus ();

    return_stream #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_W    (DATA_W),
        .READ_LAT  (READ_LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    assign bus.slv_reg0 = {27'b0, soft_clr, 2'b0, im_start, im_work};

    // synchronous BRAM with READ_LAT cycles of latency
    always @(posedge clk) begin
        rd_pipe[0] <= mem[bus.addra];
        for (int i = 1; i < READ_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign bus.douta = rd_pipe[READ_LAT-1];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic push_expected(input int b, input int e);
        for (int a = b; a <= e; a += DATA_W) begin
            word_t w;
            int    n;
            n = (e - a + 1 < DATA_W) ? (e - a + 1) : DATA_W;
            w.data = '0;
            for (int i = 0; i < n; i++) begin
`ifdef RETURN_MSB_FIRST_EN
                if (mem[a+i]) w.data[n-1-i] = 1'b1;
`else
                if (mem[a+i]) w.data[i] = 1'b1;
`endif
            end
            w.cnt = 6'(n);
            exp_q.push_back(w);
        end
    endtask

    task automatic fill_random(input int b, input int e);
        for (int a = b; a <= e; a++) mem[a] = 1'($urandom);
    endtask

    task automatic pulse_start(input bit hold);
        @(negedge clk);
        im_start = 1'b1;
        @(negedge clk);
        if (!hold) im_start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (bus.slv_reg3[2] !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_done"}, 32'(bus.slv_reg3[2]), 32'd1);
        check({name, "_busy"}, 32'(bus.slv_reg3[1]), 32'd0);
        check({name, "_err"}, 32'(bus.slv_reg3[3]), 32'd0);
        check({name, "_words_left"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_present(input string name);
        int n = 0;
        while (bus.slv_reg3[0] !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check({name, "_present"}, 32'(bus.slv_reg3[0]), 32'd1);
    endtask

    task automatic run_window(input string name, input int b, input int e, input bit hold_start);
        @(negedge clk);
        bus.slv_reg1 = {16'(e), 16'(b)};
        push_expected(b, e);
        pulse_start(hold_start);
        wait_done(name);
    endtask

    // PS side of the four-phase handshake
    initial begin
        forever begin
            @(negedge clk);
            if (ack_mode == 1) begin
                im_work = 1'b1;
            end else if (ack_mode == 2) begin
                im_work = 1'b0;
            end else if (bus.slv_reg3[0] && !im_work) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                im_work = 1'b1;
            end else if (!bus.slv_reg3[0] && im_work) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                im_work = 1'b0;
            end
        end
    end

    // monitor: every rising om_work is one presented word
    initial begin
        logic  prev;
        word_t w;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.slv_reg3[0] && !prev) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_word: actual=0x%0h required=none", bus.slv_reg2);
                end else begin
                    w = exp_q.pop_front();
                    check("word_data", bus.slv_reg2, w.data);
                    check("word_status", bus.slv_reg3, {18'b0, w.cnt, 8'b0000_0011});
                end
            end
            prev = bus.slv_reg3[0];
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] pat_a;
        logic [7:0] pat_b;
        int b;
        int e;

        bus.slv_reg1 = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_reg2", bus.slv_reg2, 32'd0);
        check("reset_reg3", bus.slv_reg3, 32'd0);
        check("reset_addra", 32'(bus.addra), 32'd0);

        pat_a = 8'hA5;
        pat_b = 8'h3C;
        for (int i = 0; i < 8; i++) begin
            mem[3+i]  = pat_a[i];
            mem[11+i] = pat_b[i];
        end
        run_window("two_words", 3, 18, 1'b1);
        repeat (30) @(negedge clk);
        check("held_start_done", 32'(bus.slv_reg3[2]), 32'd1);
        check("held_start_busy", 32'(bus.slv_reg3[1]), 32'd0);
        im_start = 1'b0;

        fill_random(3, 12);
        run_window("tail_word", 3, 12, 1'b0);

        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.slv_reg1 = {16'd5, 16'd20};
        @(negedge clk);
        im_start = 1'b1;
        repeat (2) @(negedge clk);
        check("range_err", 32'(bus.slv_reg3[3]), 32'd1);
        check("range_done", 32'(bus.slv_reg3[2]), 32'd1);
        check("range_busy", 32'(bus.slv_reg3[1]), 32'd0);
        check("range_addra", 32'(bus.addra), 32'd0);
        im_start = 1'b0;
        repeat (5) @(negedge clk);
        check("range_addra_later", 32'(bus.addra), 32'd0);

        fill_random(77, 77);
        run_window("single_bit", 77, 77, 1'b0);

        fill_random(MEM_DEPTH - 6, MEM_DEPTH - 1);
        run_window("top_edge", MEM_DEPTH - 6, MEM_DEPTH - 1, 1'b0);
        check("top_edge_addra", 32'(bus.addra), 32'(MEM_DEPTH - 1));

        for (int t = 0; t < 15; t++) begin
            b = int'($urandom_range(0, MEM_DEPTH - 1));
            e = b + int'($urandom_range(0, 40));
            if (e > MEM_DEPTH - 1) e = MEM_DEPTH - 1;
            fill_random(b, e);
            run_window("random", b, e, 1'b0);
        end

        // im_work already high before start
        @(negedge clk);
        ack_mode = 1;
        @(negedge clk);
        fill_random(100, 115);
        bus.slv_reg1 = {16'd115, 16'd100};
        push_expected(100, 115);
        pulse_start(1'b0);
        wait_present("hold");
        repeat (20) @(negedge clk);
        check("hold_words_left", 32'(exp_q.size()), 32'd1);
        check("hold_om_work", 32'(bus.slv_reg3[0]), 32'd0);
        check("hold_busy", 32'(bus.slv_reg3[1]), 32'd1);
        ack_mode = 0;
        wait_done("hold_release");

        // soft clear while the first word is presented
        ack_mode = 2;
        fill_random(200, 230);
        bus.slv_reg1 = {16'd230, 16'd200};
        push_expected(200, 230);
        pulse_start(1'b0);
        wait_present("clear");
        soft_clr = 1'b1;
        @(negedge clk);
        soft_clr = 1'b0;
        check("clear_reg2", bus.slv_reg2, 32'd0);
        check("clear_reg3", bus.slv_reg3, 32'd0);
        check("clear_addra", 32'(bus.addra), 32'd0);
        check("clear_words_left", 32'(exp_q.size()), 32'd3);
        exp_q.delete();
        ack_mode = 0;
        repeat (5) @(negedge clk);
        check("clear_idle_reg3", bus.slv_reg3, 32'd0);
        run_window("replay", 200, 230, 1'b0);

        repeat (10) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
